// File: rtl/joystick_input.sv
// Joystick front-end: per-bit 2-flop sync, debounce, opposite-direction suppression,
// optional port swap and per-port change strobe. Autofire is built only with JOY_AUTOFIRE_EN.
module joystick_input #(
  parameter int NUM_PORTS       = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_BITS        = 17,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int AUTOFIRE_PERIOD = 2000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [0:5*NUM_PORTS-1]   joy_raw,
  input  logic                     swap_ports,
  input  logic [0:NUM_PORTS-1]     autofire,
  output logic [0:5*NUM_PORTS-1]   joy_out,
  output logic [0:NUM_PORTS-1]     changed
);

  localparam int NB = 5 * NUM_PORTS;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [0:NB-1]       sync_p0;
  logic [0:NB-1]       sync_p1;
  logic [0:NB-1]       pressed;
  logic [0:NB-1]       stable_p2;
  logic [CNT_BITS-1:0] db_cnt [NB];
  logic [0:NUM_PORTS-1] fire_out;
  logic [0:NB-1]       proc;
  logic [0:NB-1]       next_out;

  // Stage p0/p1: two-flop synchroniser, preset to the released pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= {NB{ACTIVE_LOW}};
      sync_p1 <= {NB{ACTIVE_LOW}};
    end else begin
      sync_p0 <= joy_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed = ACTIVE_LOW ? ~sync_p1 : sync_p1;

  // Stage p2: per-bit debounce; any return to the stable level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_p2 <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (pressed[i] == stable_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable_p2[i] <= pressed[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_BITS'(1);
        end
      end
    end
  end

`ifdef JOY_AUTOFIRE_EN
  localparam int AF_BITS = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;
  localparam logic [AF_BITS-1:0] AF_LAST = AF_BITS'(AUTOFIRE_PERIOD - 1);

  logic [AF_BITS-1:0]   af_cnt [NUM_PORTS];
  logic [0:NUM_PORTS-1] af_phase;

  // Phase 0 means "pressed", so the first output cycle after acceptance shows fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_phase <= '0;
      for (int p = 0; p < NUM_PORTS; p++) af_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!(stable_p2[5*p] && autofire[p])) begin
          af_cnt[p]   <= '0;
          af_phase[p] <= 1'b0;
        end else if (af_cnt[p] == AF_LAST) begin
          af_cnt[p]   <= '0;
          af_phase[p] <= ~af_phase[p];
        end else begin
          af_cnt[p] <= af_cnt[p] + AF_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    fire_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) fire_out[p] = stable_p2[5*p] & ~af_phase[p];
  end
`else
  logic unused_autofire;
  assign unused_autofire = ^autofire;

  always_comb begin
    fire_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) fire_out[p] = stable_p2[5*p];
  end
`endif

  // Opposing directions cancel; fire passes straight through
  always_comb begin
    proc = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      proc[5*p]     = fire_out[p];
      proc[5*p + 1] = stable_p2[5*p + 1] & ~stable_p2[5*p + 2];
      proc[5*p + 2] = stable_p2[5*p + 2] & ~stable_p2[5*p + 1];
      proc[5*p + 3] = stable_p2[5*p + 3] & ~stable_p2[5*p + 4];
      proc[5*p + 4] = stable_p2[5*p + 4] & ~stable_p2[5*p + 3];
    end
  end

  generate
    if (NUM_PORTS >= 2) begin : g_swap
      always_comb begin
        next_out = proc;
        if (swap_ports) begin
          next_out[0:4] = proc[5:9];
          next_out[5:9] = proc[0:4];
        end
      end
    end else begin : g_noswap
      logic unused_swap;
      assign unused_swap = swap_ports;
      assign next_out    = proc;
    end
  endgenerate

  // Stage p3: output register; changed is computed against the value being replaced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy_out <= '0;
      changed <= '0;
    end else begin
      joy_out <= next_out;
      for (int p = 0; p < NUM_PORTS; p++)
        changed[p] <= (next_out[5*p +: 5] != joy_out[5*p +: 5]);
    end
  end

endmodule

// File: tb/tb_joystick_input.sv
// Bench for joystick_input: table of {inputs, hold edges, expected outputs} rows,
// with expectations queued on drive and compared when their edge count comes due.
module tb_joystick_input;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:9] joy_raw = 10'b1111111111;
  logic       swap_ports = 1'b0;
  logic [0:1] autofire = 2'b00;
  logic [0:9] joy_out;
  logic [0:1] changed;

  joystick_input #(
    .NUM_PORTS(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_BITS(3),
    .ACTIVE_LOW(1'b1),
    .AUTOFIRE_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .joy_raw(joy_raw),
    .swap_ports(swap_ports),
    .autofire(autofire),
    .joy_out(joy_out),
    .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [0:9] raw;
    logic       swap;
    logic [0:1] af;
    int         n;
    logic [0:9] out;
    logic [0:1] chg;
  } vec_t;

  typedef struct {
    int         due;
    logic [0:9] out;
    logic [0:1] chg;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t cur;
  int   edge_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   seq_id = 1000;

  localparam logic [0:9] R = 10'b1111111111;
  localparam logic [0:9] Z = 10'b0000000000;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      cur = sb.pop_front();
      checks++;
      if (cur.due != edge_cnt) begin
        errors++;
        $display("FAIL row%0d: check missed at edge %0d, due edge %0d", cur.id, edge_cnt, cur.due);
      end else if (joy_out !== cur.out || changed !== cur.chg) begin
        errors++;
        $display("FAIL row%0d: joy_out=%b changed=%b, expected joy_out=%b changed=%b",
                 cur.id, joy_out, changed, cur.out, cur.chg);
      end
    end
  end

  task automatic add(input logic r, input logic [0:9] raw, input logic swap, input logic [0:1] af,
                     input int n, input logic [0:9] out, input logic [0:1] chg);
    vec_t v;
    v.r = r; v.raw = raw; v.swap = swap; v.af = af; v.n = n; v.out = out; v.chg = chg;
    vecs.push_back(v);
  endtask

  // Drive two time units after a falling edge so the monitor samples before any async reset lands
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    rst_n = v.r; joy_raw = v.raw; swap_ports = v.swap; autofire = v.af;
    e.due = edge_cnt + v.n; e.out = v.out; e.chg = v.chg; e.id = id;
    sb.push_back(e);
    repeat (v.n) @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic run(input logic r, input logic [0:9] raw, input logic swap, input logic [0:1] af,
                     input int n, input logic [0:9] out, input logic [0:1] chg);
    vec_t v;
    v.r = r; v.raw = raw; v.swap = swap; v.af = af; v.n = n; v.out = out; v.chg = chg;
    apply(v, seq_id);
    seq_id++;
  endtask

  initial begin
    // reset and idle
    add(0, R, 0, 2'b00, 2, Z, 2'b00);
    add(1, R, 0, 2'b00, 3, Z, 2'b00);
    // port 0 fire: visible exactly 7 edges after the pin drops, one-cycle strobe
    add(1, 10'b0111111111, 0, 2'b00, 6, Z, 2'b00);
    add(1, 10'b0111111111, 0, 2'b00, 1, 10'b1000000000, 2'b10);
    add(1, 10'b0111111111, 0, 2'b00, 1, 10'b1000000000, 2'b00);
    add(1, R, 0, 2'b00, 6, 10'b1000000000, 2'b00);
    add(1, R, 0, 2'b00, 1, Z, 2'b10);
    add(1, R, 0, 2'b00, 1, Z, 2'b00);
    // 3-cycle glitch is rejected
    add(1, 10'b0111111111, 0, 2'b00, 3, Z, 2'b00);
    add(1, R, 0, 2'b00, 10, Z, 2'b00);
    // port 1 left+right cancel, then right released
    add(1, 10'b1111110011, 0, 2'b00, 8, Z, 2'b00);
    add(1, 10'b1111110111, 0, 2'b00, 6, Z, 2'b00);
    add(1, 10'b1111110111, 0, 2'b00, 1, 10'b0000001000, 2'b01);
    add(1, 10'b1111110111, 0, 2'b00, 1, 10'b0000001000, 2'b00);
    add(1, R, 0, 2'b00, 7, Z, 2'b01);
    add(1, R, 0, 2'b00, 1, Z, 2'b00);
    // port 0 up, then swap / unswap
    add(1, 10'b1111011111, 0, 2'b00, 7, 10'b0000100000, 2'b10);
    add(1, 10'b1111011111, 1, 2'b00, 1, 10'b0000000001, 2'b11);
    add(1, 10'b1111011111, 1, 2'b00, 1, 10'b0000000001, 2'b00);
    add(1, 10'b1111011111, 0, 2'b00, 1, 10'b0000100000, 2'b11);
    add(1, R, 0, 2'b00, 7, Z, 2'b10);
    add(1, R, 0, 2'b00, 1, Z, 2'b00);
    // up+down cancel while fire passes
    add(1, 10'b0110011111, 0, 2'b00, 6, Z, 2'b00);
    add(1, 10'b0110011111, 0, 2'b00, 1, 10'b1000000000, 2'b10);
    add(1, R, 0, 2'b00, 7, Z, 2'b10);
    add(1, R, 0, 2'b00, 1, Z, 2'b00);
    // two bits accepted on the same edge give one strobe
    add(1, 10'b1111101110, 0, 2'b00, 7, 10'b0000010001, 2'b01);
    add(1, 10'b1111101110, 0, 2'b00, 1, 10'b0000010001, 2'b00);
    add(1, R, 0, 2'b00, 7, Z, 2'b01);
    add(1, R, 0, 2'b00, 1, Z, 2'b00);
    // reset mid-debounce clears outputs and restarts the full latency
    add(1, 10'b1111011111, 0, 2'b00, 7, 10'b0000100000, 2'b10);
    add(1, 10'b1111011111, 0, 2'b00, 1, 10'b0000100000, 2'b00);
    add(1, 10'b0111011111, 0, 2'b00, 4, 10'b0000100000, 2'b00);
    add(0, 10'b0111011111, 0, 2'b00, 1, Z, 2'b00);
    add(1, 10'b0111011111, 0, 2'b00, 6, Z, 2'b00);
    add(1, 10'b0111011111, 0, 2'b00, 1, 10'b1000100000, 2'b10);
    add(1, R, 0, 2'b00, 7, Z, 2'b10);
    add(1, R, 0, 2'b00, 1, Z, 2'b00);

    @(negedge clk);
    #2;
    foreach (vecs[i]) apply(vecs[i], i);

`ifdef JOY_AUTOFIRE_EN
    // autofire: 8 cycles pressed, 8 released, strobe on each toggle; stops when fire releases
    run(1, 10'b0111111111, 0, 2'b10, 6, Z, 2'b00);
    run(1, 10'b0111111111, 0, 2'b10, 1, 10'b1000000000, 2'b10);
    run(1, 10'b0111111111, 0, 2'b10, 7, 10'b1000000000, 2'b00);
    run(1, 10'b0111111111, 0, 2'b10, 1, Z, 2'b10);
    run(1, 10'b0111111111, 0, 2'b10, 7, Z, 2'b00);
    run(1, 10'b0111111111, 0, 2'b10, 1, 10'b1000000000, 2'b10);
    run(1, R, 0, 2'b10, 6, 10'b1000000000, 2'b00);
    run(1, R, 0, 2'b10, 1, Z, 2'b10);
    run(1, R, 0, 2'b10, 16, Z, 2'b00);
    run(1, R, 0, 2'b00, 1, Z, 2'b00);
`else
    // without the feature, autofire requests leave fire steady
    run(1, 10'b0111111111, 0, 2'b11, 7, 10'b1000000000, 2'b10);
    run(1, 10'b0111111111, 0, 2'b11, 20, 10'b1000000000, 2'b00);
    run(1, R, 0, 2'b11, 7, Z, 2'b10);
    run(1, R, 0, 2'b00, 1, Z, 2'b00);
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
